dm_responder: RTL and testbench

Data-memory responder serving the MEM-stage load/store port of the pipelined RISC-V core. It accepts one request at a time over a valid/ready handshake and holds it for a configurable latency. It then commits stores with byte-lane masking, or returns loads sign- or zero-extended according to DMType. The response is held until the pipeline consumes it, so the core can be verified against realistic multi-cycle memory before a cache exists.

---
 rtl/dm_responder_pkg.sv | 37 +++
 rtl/dm_lane_ext.sv | 66 ++++++
 rtl/dm_responder.sv | 177 +++++++++++++++++
 tb/tb_dm_responder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_responder_pkg.sv
// -----------------------------------------------------------------------------
// dm_responder_pkg
//   Shared definitions for the data-memory responder:
//   - DMType access codes (shared with the core's ctrl decoder)
//   - FSM state encoding for dm_responder
//   - helpers classifying illegal and misaligned accesses
// -----------------------------------------------------------------------------
package dm_responder_pkg;

    // DMType access codes
    localparam logic [2:0] dm_word              = 3'b000;
    localparam logic [2:0] dm_halfword          = 3'b001;
    localparam logic [2:0] dm_halfword_unsigned = 3'b010;
    localparam logic [2:0] dm_byte              = 3'b011;
    localparam logic [2:0] dm_byte_unsigned     = 3'b100;

    // Responder FSM states
    localparam logic [1:0] DMR_IDLE = 2'd0;
    localparam logic [1:0] DMR_WAIT = 2'd1;
    localparam logic [1:0] DMR_RESP = 2'd2;

    // Codes 101..111 have no defined access.
    function automatic logic dm_illegal(input logic [2:0] dmtype);
        return dmtype > dm_byte_unsigned;
    endfunction

    // True when a half/word access is not naturally aligned.
    function automatic logic dm_misaligned(input logic [2:0] dmtype,
                                           input logic [1:0] lane);
        case (dmtype)
            dm_word:                           return lane != 2'b00;
            dm_halfword, dm_halfword_unsigned: return lane[0];
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// -----------------------------------------------------------------------------
// dm_lane_ext
//   Combinational little-endian lane steering for the data-memory responder.
//   Ports:
//     dmtype     in  3   access type (DMType code)
//     lane       in  2   addr[1:0] of the access
//     rdata_raw  in  32  raw memory word being read
//     wdata_raw  in  32  raw store data; low byte/half used for narrow stores
//     load_data  out 32  selected lane, sign- or zero-extended
//     byte_en    out 4   store byte enables
//     store_data out 32  store data replicated onto its lanes
//   Misaligned half/word lanes are aligned down: half uses lane[1] only,
//   word ignores lane entirely. Illegal dmtype yields all-zero outputs.
// -----------------------------------------------------------------------------
module dm_lane_ext
    import dm_responder_pkg::*;
(
    input  logic [2:0]  dmtype,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata_raw,
    input  logic [31:0] wdata_raw,
    output logic [31:0] load_data,
    output logic [3:0]  byte_en,
    output logic [31:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = rdata_raw[{lane, 3'b000} +: 8];
        half_sel   = lane[1] ? rdata_raw[31:16] : rdata_raw[15:0];
        load_data  = '0;
        byte_en    = '0;
        store_data = '0;
        case (dmtype)
            dm_word: begin
                load_data  = rdata_raw;
                byte_en    = 4'b1111;
                store_data = wdata_raw;
            end
            dm_halfword: begin
                load_data  = {{16{half_sel[15]}}, half_sel};
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata_raw[15:0]}};
            end
            dm_halfword_unsigned: begin
                load_data  = {16'h0000, half_sel};
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata_raw[15:0]}};
            end
            dm_byte: begin
                load_data  = {{24{byte_sel[7]}}, byte_sel};
                byte_en    = 4'b0001 << lane;
                store_data = {4{wdata_raw[7:0]}};
            end
            dm_byte_unsigned: begin
                load_data  = {24'h000000, byte_sel};
                byte_en    = 4'b0001 << lane;
                store_data = {4{wdata_raw[7:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
//   Data-memory responder for the MEM-stage load/store port. Accepts one
//   request at a time, holds it LATENCY cycles, then commits a byte-masked
//   store or returns an extended load. The response is held until consumed.
//   Parameters:
//     DEPTH    memory size in 32-bit words (power of two)
//     LATENCY  cycles from acceptance to resp_valid (>= 1)
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     req_valid/req_ready      request handshake
//     req_we, req_dmtype       store select, access type
//     req_addr, req_wdata      byte address, store data
//     resp_valid/resp_ready    response handshake
//     resp_rdata, resp_err     load data (0 for stores/errors), reject flag
//   Configuration macro:
//     DM_MISALIGN_CHECK_EN  misaligned half/word accesses complete with
//                           resp_err; otherwise they are aligned down.
// -----------------------------------------------------------------------------
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_dmtype,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(LATENCY + 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;

    logic          hold_we;
    logic [2:0]    hold_dmtype;
    logic [AW+1:0] hold_addr;
    logic [31:0]   hold_wdata;

    logic [31:0]   mem [DEPTH];

    logic          cur_we;
    logic [2:0]    cur_dmtype;
    logic [AW+1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [AW-1:0] idx;

    logic          accept;
    logic          commit;
    logic          misalign;
    logic          err;
    logic [31:0]   load_data;
    logic [31:0]   store_data;
    logic [3:0]    byte_en;

    // Upper address bits alias; they never reach the array.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW+2];

    assign req_ready  = (state == DMR_IDLE) & ~rst;
    assign accept     = req_valid & req_ready;
    assign resp_valid = (state == DMR_RESP);

    // With LATENCY==1 the commit edge is the acceptance edge, before the
    // holding registers are loaded, so the live request fields are used then.
    always_comb begin
        if (state == DMR_IDLE) begin
            cur_we     = req_we;
            cur_dmtype = req_dmtype;
            cur_addr   = req_addr[AW+1:0];
            cur_wdata  = req_wdata;
        end else begin
            cur_we     = hold_we;
            cur_dmtype = hold_dmtype;
            cur_addr   = hold_addr;
            cur_wdata  = hold_wdata;
        end
        idx = cur_addr[AW+1:2];
    end

    always_comb begin
        if (LATENCY == 1) begin
            commit = accept;
        end else begin
            commit = (state == DMR_WAIT) && (cnt == CW'(1)) && !rst;
        end
    end

`ifdef DM_MISALIGN_CHECK_EN
    assign misalign = dm_misaligned(cur_dmtype, cur_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign err = dm_illegal(cur_dmtype) | misalign;

    dm_lane_ext u_lane_ext (
        .dmtype     (cur_dmtype),
        .lane       (cur_addr[1:0]),
        .rdata_raw  (mem[idx]),
        .wdata_raw  (cur_wdata),
        .load_data  (load_data),
        .byte_en    (byte_en),
        .store_data (store_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= DMR_IDLE;
            cnt         <= '0;
            hold_we     <= 1'b0;
            hold_dmtype <= '0;
            hold_addr   <= '0;
            hold_wdata  <= '0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
        end else begin
            case (state)
                DMR_IDLE: begin
                    if (accept) begin
                        hold_we     <= req_we;
                        hold_dmtype <= req_dmtype;
                        hold_addr   <= req_addr[AW+1:0];
                        hold_wdata  <= req_wdata;
                        if (LATENCY > 1) begin
                            state <= DMR_WAIT;
                            cnt   <= CW'(LATENCY - 1);
                        end else begin
                            state <= DMR_RESP;
                        end
                    end
                end
                DMR_WAIT: begin
                    if (cnt == CW'(1)) begin
                        state <= DMR_RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DMR_RESP: begin
                    if (resp_ready) begin
                        state <= DMR_IDLE;
                    end
                end
                default: state <= DMR_IDLE;
            endcase

            if (commit) begin
                resp_rdata <= (cur_we | err) ? '0 : load_data;
                resp_err   <= err;
            end
        end
    end

    // Memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (commit && cur_we && !err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[idx][8*i +: 8] <= store_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_responder
//   Scoreboard bench for dm_responder. The driver pushes the expected
//   response (from a word-array reference model) when it issues a request;
//   an independent monitor compares each response as it appears, checks the
//   acceptance-to-response latency and output stability while stalled.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dm_responder;
    import dm_responder_pkg::*;

    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_dmtype;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_dmtype (req_dmtype),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          hs_cyc      = -100;
    int          last_acc    = 0;
    bit          seen        = 0;
    bit          bp_hold     = 0;
    bit          bp_force    = 0;
    bit          busy        = 0;
    logic [31:0] held_rdata;
    logic        held_err;
    logic [31:0] model_mem [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference model: word array indexed by address/4 modulo DEPTH.
    function automatic exp_t ref_access(input logic we, input logic [2:0] dt,
                                        input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        int unsigned w;
        int unsigned off;
        logic [31:0] v;
        bit          bad;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        bad     = (dt > 3'd4);
`ifdef DM_MISALIGN_CHECK_EN
        if (dt == dm_word && (addr % 4) != 0) bad = 1;
        if ((dt == dm_halfword || dt == dm_halfword_unsigned) && (addr % 2) != 0) bad = 1;
`endif
        if (bad) begin
            e.err = 1'b1;
            return e;
        end
        w = (addr / 4) % DEPTH;
        case (dt)
            dm_word:                           off = 0;
            dm_halfword, dm_halfword_unsigned: off = ((addr % 4) / 2) * 2;
            default:                           off = addr % 4;
        endcase
        if (we) begin
            case (dt)
                dm_word: model_mem[w] = wdata;
                dm_halfword, dm_halfword_unsigned:
                    model_mem[w] = (model_mem[w] & ~(32'hFFFF << (8*off))) | ((wdata & 32'hFFFF) << (8*off));
                default:
                    model_mem[w] = (model_mem[w] & ~(32'hFF << (8*off))) | ((wdata & 32'hFF) << (8*off));
            endcase
            return e;
        end
        v = model_mem[w] >> (8*off);
        case (dt)
            dm_word:              e.rdata = v;
            dm_halfword:          e.rdata = (v & 32'hFFFF) | (v[15] ? 32'hFFFF0000 : 32'h0);
            dm_halfword_unsigned: e.rdata = v & 32'hFFFF;
            dm_byte:              e.rdata = (v & 32'hFF) | (v[7] ? 32'hFFFFFF00 : 32'h0);
            default:              e.rdata = v & 32'hFF;
        endcase
        return e;
    endfunction

    task automatic issue(input logic we, input logic [2:0] dt, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit track);
        int n;
        busy = 1;
        if (track) exp_q.push_back(ref_access(we, dt, addr, wdata));
        @(posedge clk); #1;
        req_we     = we;
        req_dmtype = dt;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: req_ready=%b expected 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        busy = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || resp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || resp_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: outstanding=%0d resp_valid=%b expected 0", exp_q.size(), resp_valid);
        end
    endtask

    // Response consumer
    initial begin
        resp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bp_hold)       resp_ready = 1'b0;
            else if (bp_force) resp_ready = 1'b1;
            else               resp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor
    always @(negedge clk) begin : monitor
        exp_t e;
        int   a;
        if (!rst) begin
            cyc++;
            if (req_valid && req_ready) begin
                acc_q.push_back(cyc);
                last_acc = cyc;
            end
            if (resp_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0 || acc_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_resp: resp_valid=1 expected 0");
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        check("resp_rdata", resp_rdata, e.rdata);
                        check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                        check("latency", 32'(cyc - a), LATENCY);
                    end
                    seen       = 1;
                    held_rdata = resp_rdata;
                    held_err   = resp_err;
                end else begin
                    check("hold_rdata", resp_rdata, held_rdata);
                    check("hold_err", {31'b0, resp_err}, {31'b0, held_err});
                    check("ready_in_resp", {31'b0, req_ready}, 32'h0);
                end
                if (resp_ready) begin
                    seen   = 0;
                    hs_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_dmtype = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_req_ready",  {31'b0, req_ready},  32'h0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata,          32'h0);
        check("rst_resp_err",   {31'b0, resp_err},   32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'b0, req_ready}, 32'h1);

        // Basic word round trip
        issue(1, dm_word, 32'h10, 32'hDEADBEEF, 1);
        issue(0, dm_word, 32'h10, 32'h0, 1);
        // Byte lanes
        issue(1, dm_word,          32'h20, 32'h11223344, 1);
        issue(1, dm_byte,          32'h23, 32'h00000080, 1);
        issue(0, dm_word,          32'h20, 32'h0, 1);
        issue(0, dm_byte,          32'h23, 32'h0, 1);
        issue(0, dm_byte_unsigned, 32'h23, 32'h0, 1);
        // Half lanes
        issue(1, dm_word,              32'h30, 32'h0, 1);
        issue(1, dm_halfword,          32'h32, 32'h00008001, 1);
        issue(0, dm_halfword,          32'h32, 32'h0, 1);
        issue(0, dm_halfword_unsigned, 32'h32, 32'h0, 1);
        issue(0, dm_word,              32'h30, 32'h0, 1);
        // Illegal dmtype store leaves memory untouched
        issue(1, 3'b111, 32'h10, 32'h0BADF00D, 1);
        issue(0, dm_word, 32'h10, 32'h0, 1);
        // Misaligned word load
        issue(1, dm_word, 32'h40, 32'hCAFEF00D, 1);
        issue(0, dm_word, 32'h41, 32'h0, 1);
        // Address aliasing
        issue(1, dm_word, DEPTH * 4, 32'hA5A50001, 1);
        issue(0, dm_word, 32'h0, 32'h0, 1);
        drain();

        // Backpressure: stall RESP, present a second request meanwhile
        bp_hold = 1;
        issue(0, dm_word, 32'h10, 32'h0, 1);
        fork
            issue(0, dm_byte_unsigned, 32'h23, 32'h0, 1);
        join_none
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            @(negedge clk);
            check("bp_req_ready",  {31'b0, req_ready},  32'h0);
            check("bp_resp_valid", {31'b0, resp_valid}, 32'h1);
        end
        bp_force = 1;
        bp_hold  = 0;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_next_accept", 32'(last_acc - hs_cyc), 32'h1);
        bp_force = 0;
        drain();

        // Reset during WAIT discards the uncommitted store
        issue(1, dm_word, 32'h50, 32'h12345678, 1);
        drain();
        issue(1, dm_word, 32'h50, 32'h00000005, 0);
        rst = 1'b1;
        acc_q.delete();
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            check("wait_rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        end
        issue(0, dm_word, 32'h50, 32'h0, 1);
        drain();

        // Randomized traffic over an initialized region, with aliased upper bits
        for (int i = 0; i < 32; i++) begin
            issue(1, dm_word, 32'h100 + 32'(4 * i), $urandom, 1);
        end
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            logic [2:0]  dt;
            a  = 32'h100 + 32'($urandom_range(0, 127));
            a  = a | ($urandom & 32'hFFFF_F000);
            dt = 3'($urandom_range(0, 7));
            issue(1'($urandom_range(0, 1)), dt, a, $urandom, 1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
